track_sequencer: RTL and testbench

//  Plays a queue of flash-resident audio tracks back to back. Owns the flash_manager read side
//  (raddr/doread), converts each track index to a flash address and streams one sample per AC97

---
 rtl/track_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_track_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_sequencer.sv
// ---------------------------------------------------------------------------
// track_sequencer
//   Plays a queue of flash-resident audio tracks back to back. Track indices
//   are pushed into a small FIFO; on start the FSM pops them one at a time,
//   converts each index into a flash address window and streams one sample
//   per AC97 ready strobe from flash_manager to the headphone output.
//
// Ports
//   clock        in   system clock
//   reset_b      in   synchronous active-low reset
//   enq_valid    in   push enq_index this cycle
//   enq_index    in   [4:0] track index to queue
//   enq_ready    out  queue not full
//   flush        in   abort playback and empty the queue
//   start        in   begin playing the queue (sampled only when idle)
//   ready        in   AC97 one-cycle sample strobe
//   frdata       in   [15:0] flash read data, sample is frdata[15:8]
//   fm_busy      in   flash_manager busy
//   raddr        out  [22:0] flash read address
//   doread       out  flash_manager read enable
//   to_ac97_data out  [7:0] PCM sample
//   playing      out  high while loading, priming or playing
//   done         out  one-cycle pulse at sequence end
//   underrun     out  one-cycle pulse: strobe arrived while flash busy
//   q_count      out  [3:0] entries in the queue
// ---------------------------------------------------------------------------
module track_sequencer #(
    parameter int TRACK_LENGTH = 69000,
    parameter int QDEPTH       = 8,
    parameter int SKIP_INDEX   = 28,
    parameter int END_INDEX    = 31
) (
    input  logic        clock,
    input  logic        reset_b,
    input  logic        enq_valid,
    input  logic [4:0]  enq_index,
    output logic        enq_ready,
    input  logic        flush,
    input  logic        start,
    input  logic        ready,
    input  logic [15:0] frdata,
    input  logic        fm_busy,
    output logic [22:0] raddr,
    output logic        doread,
    output logic [7:0]  to_ac97_data,
    output logic        playing,
    output logic        done,
    output logic        underrun,
    output logic [3:0]  q_count
);

    localparam int PW = $clog2(QDEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PRIME = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0]  QFULL   = 4'(QDEPTH);
    localparam logic [22:0] TL23    = 23'(TRACK_LENGTH);
    localparam logic [4:0]  SKIP5   = 5'(SKIP_INDEX);
    localparam logic [4:0]  END5    = 5'(END_INDEX);

    logic [4:0]    mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]    count_q;

    logic [2:0]    state_q, state_d;
    logic [22:0]   raddr_q, raddr_d;
    logic [22:0]   end_addr_q, end_addr_d;
    logic [7:0]    data_q, data_d;
    logic          underrun_q, underrun_d;

    logic          push, pop;
    logic [4:0]    head;
    logic [22:0]   head_base;

    // Only the upper byte of the flash word carries audio.
    logic          unused_frdata;
    assign unused_frdata = ^frdata[7:0];

    assign enq_ready = (count_q != QFULL);
    assign head      = mem_q[rd_ptr_q];
    // 23-bit product: the largest window end (31*L+L for L=69000) still fits.
    assign head_base = 23'(head) * TL23;

    // Flush overrides both queue operations.
    assign push = enq_valid & enq_ready & ~flush;
    assign pop  = (state_q == S_LOAD) & (count_q != 4'd0) & ~flush;

    // ---------------- index FIFO ----------------
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_index;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_b || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- playback FSM ----------------
    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        end_addr_d = end_addr_q;
        data_d     = data_q;
        underrun_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && count_q != 4'd0) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (count_q == 4'd0) begin
                    state_d = S_DONE;
                end else if (head == SKIP5) begin
                    // Popping the last entry ends the sequence unless a new
                    // index lands in the same cycle.
                    if (count_q == 4'd1 && !push) state_d = S_DONE;
                end else if (head == END5) begin
                    state_d = S_DONE;
                end else begin
                    raddr_d    = head_base;
                    end_addr_d = head_base + TL23;
                    state_d    = S_PRIME;
                end
            end
            S_PRIME: begin
                if (!fm_busy) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (ready) begin
                    if (fm_busy) begin
                        underrun_d = 1'b1;
                    end else if (raddr_q < end_addr_q) begin
                        data_d  = frdata[15:8];
                        raddr_d = raddr_q + 23'd1;
                    end else begin
                        state_d = (count_q != 4'd0) ? S_LOAD : S_DONE;
                    end
                end
            end
            S_DONE: begin
                raddr_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort: silent return to idle, no done pulse.
        if (flush && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            raddr_d    = '0;
            end_addr_d = '0;
            data_d     = '0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_q    <= S_IDLE;
            raddr_q    <= '0;
            end_addr_q <= '0;
            data_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            end_addr_q <= end_addr_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
        end
    end

    assign raddr        = raddr_q;
    assign to_ac97_data = data_q;
    assign underrun     = underrun_q;
    assign q_count      = count_q;
    assign doread       = (state_q == S_PRIME) || (state_q == S_PLAY);
    assign playing      = (state_q == S_LOAD) || (state_q == S_PRIME) || (state_q == S_PLAY);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_track_sequencer.sv
// ---------------------------------------------------------------------------
// tb_track_sequencer
//   Directed and randomized playback sequences against a queue-level model.
//   A short track length keeps each sequence to a few hundred cycles; the
//   flash data is a function of the address so each sample can be traced.
// ---------------------------------------------------------------------------
module tb_track_sequencer;

    localparam int TL = 6;

    logic        clock;
    logic        reset_b;
    logic        enq_valid;
    logic [4:0]  enq_index;
    logic        enq_ready;
    logic        flush;
    logic        start;
    logic        ready;
    logic [15:0] frdata;
    logic        fm_busy;
    logic [22:0] raddr;
    logic        doread;
    logic [7:0]  to_ac97_data;
    logic        playing;
    logic        done;
    logic        underrun;
    logic [3:0]  q_count;

    logic [7:0]  key;
    bit          ready_auto;
    int          gap;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    int          mq[$];
    int          exp_addr[$];
    logic [7:0]  exp_data;

    // observed samples
    int          obs_a[$];
    logic [7:0]  obs_d[$];
    logic [22:0] prev_raddr;
    int          und_cnt;
    int          und_base;

    track_sequencer #(.TRACK_LENGTH(TL)) dut (
        .clock        (clock),
        .reset_b      (reset_b),
        .enq_valid    (enq_valid),
        .enq_index    (enq_index),
        .enq_ready    (enq_ready),
        .flush        (flush),
        .start        (start),
        .ready        (ready),
        .frdata       (frdata),
        .fm_busy      (fm_busy),
        .raddr        (raddr),
        .doread       (doread),
        .to_ac97_data (to_ac97_data),
        .playing      (playing),
        .done         (done),
        .underrun     (underrun),
        .q_count      (q_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Flash content: sample byte is the address low byte scrambled by key.
    assign frdata = {raddr[7:0] ^ key, 8'h5A};

    function automatic logic [7:0] sample_of(input int addr);
        logic [7:0] a;
        a = addr[7:0];
        return a ^ key;
    endfunction

    // Ready strobe generator: one-cycle pulses with random gaps.
    initial begin
        gap = 0;
        forever begin
            @(negedge clock);
            if (ready_auto) begin
                if (ready) begin
                    ready = 1'b0;
                end else if (gap == 0) begin
                    ready = 1'b1;
                    gap = $urandom_range(1, 5);
                end else begin
                    gap--;
                end
            end
        end
    end

    // Every +1 step of raddr is one consumed sample.
    initial begin
        prev_raddr = '0;
        und_cnt = 0;
        forever begin
            @(negedge clock);
            if (raddr == prev_raddr + 23'd1) begin
                obs_a.push_back(int'(prev_raddr));
                obs_d.push_back(to_ac97_data);
            end
            if (underrun) und_cnt++;
            prev_raddr = raddr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic int rand_idx();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 28;
        if (r == 1) return 31;
        return $urandom_range(0, 31);
    endfunction

    task automatic enq(input int idx);
        bit acc;
        acc = (mq.size() < 8);
        enq_valid = 1'b1;
        enq_index = 5'(idx);
        check("enq_ready", enq_ready, acc);
        tick();
        enq_valid = 1'b0;
        if (acc) mq.push_back(idx);
        check("enq_q_count", q_count, mq.size());
    endtask

    // Consume the queue by the playback rules, producing the address list.
    task automatic play_model();
        int idx;
        exp_addr.delete();
        while (mq.size() > 0) begin
            idx = mq.pop_front();
            if (idx == 31) break;
            if (idx == 28) continue;
            for (int k = 0; k < TL; k++) exp_addr.push_back(idx * TL + k);
        end
        if (exp_addr.size() > 0) exp_data = sample_of(exp_addr[exp_addr.size() - 1]);
    endtask

    task automatic finish_seq(input int exp_und);
        int n;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            tick();
            if (cyc == 8) fm_busy = 1'b0;
        end
        fm_busy = 1'b0;
        check("done_seen", done, 1);
        check("playing_in_done", playing, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("raddr_after_done", raddr, 0);
        check("doread_after_done", doread, 0);
        check("q_count_after_done", q_count, mq.size());
        check("data_held", to_ac97_data, exp_data);
        check("underrun_count", und_cnt - und_base, exp_und);
        check("sample_count", obs_a.size(), exp_addr.size());
        n = (obs_a.size() < exp_addr.size()) ? obs_a.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check("sample_addr", obs_a[i], exp_addr[i]);
            check("sample_data", obs_d[i], sample_of(exp_addr[i]));
        end
        $display("seq: %0d samples, %0d left in queue, data %0h", obs_a.size(), q_count, to_ac97_data);
    endtask

    task automatic run_seq(input bit busy_hold, input bit push_extra);
        int sz0;
        int v;
        int seen;
        bit acc;
        obs_a.delete();
        obs_d.delete();
        und_base = und_cnt;
        sz0 = mq.size();
        if (busy_hold) fm_busy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_playing", playing, (sz0 != 0));
        if (sz0 == 0) begin
            seen = 0;
            repeat (8) begin
                tick();
                if (done) seen++;
            end
            fm_busy = 1'b0;
            check("empty_start_done", seen, 0);
            check("empty_start_idle", playing, 0);
            $display("seq: start on empty queue ignored");
            return;
        end
        if (push_extra) begin
            v = rand_idx();
            acc = (sz0 < 8);
            enq_valid = 1'b1;
            enq_index = 5'(v);
            check("push_pop_ready", enq_ready, acc);
            tick();
            enq_valid = 1'b0;
            check("push_pop_count", q_count, acc ? sz0 : sz0 - 1);
            if (acc) mq.push_back(v);
        end
        play_model();
        finish_seq(0);
    endtask

    initial begin
        int n;
        int seen;
        bit reached;
        logic [22:0] r0;
        logic [7:0]  d0;

        ready_auto = 0;
        exp_data   = 8'h00;
        key        = 8'h00;

        // reset dominates live inputs
        reset_b = 1'b0; start = 1'b1; enq_valid = 1'b1; enq_index = 5'd5;
        ready = 1'b1; flush = 1'b0; fm_busy = 1'b0;
        repeat (3) tick();
        check("rst_raddr", raddr, 0);
        check("rst_doread", doread, 0);
        check("rst_data", to_ac97_data, 0);
        check("rst_playing", playing, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_q_count", q_count, 0);
        reset_b = 1'b1; start = 1'b0; enq_valid = 1'b0; ready = 1'b0;
        tick();
        ready_auto = 1;

        // empty start, then two directed sequences
        run_seq(0, 0);
        key = 8'h3C;
        enq(3); enq(28); enq(5);
        run_seq(0, 0);
        key = 8'hE1;
        enq(2); enq(31); enq(7);
        run_seq(1, 0);

        // randomized sequences (queue leftovers carry over)
        for (int s = 0; s < 20; s++) begin
            key = 8'($urandom);
            n = (s == 2) ? 10 : $urandom_range(0, 9);
            for (int i = 0; i < n; i++) enq(rand_idx());
            run_seq(s % 3 == 1, s % 2 == 0);
        end

        // flush while idle empties the queue only
        enq(9); enq(10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mq.delete();
        check("idle_flush_q_count", q_count, 0);
        check("idle_flush_playing", playing, 0);

        // underrun in PLAY
        key = 8'h77;
        obs_a.delete(); obs_d.delete(); und_base = und_cnt;
        enq(4);
        play_model();
        start = 1'b1; tick(); start = 1'b0;
        reached = 0;
        for (int c = 0; c < 500 && !reached; c++) begin
            tick();
            if (raddr == 23'(4 * TL + 2)) reached = 1;
        end
        check("underrun_reach", reached, 1);
        ready_auto = 0;
        tick();
        ready = 1'b0;
        tick();
        r0 = raddr;
        d0 = to_ac97_data;
        fm_busy = 1'b1; ready = 1'b1;
        tick();
        fm_busy = 1'b0; ready = 1'b0;
        check("underrun_pulse", underrun, 1);
        check("underrun_raddr", raddr, r0);
        check("underrun_data", to_ac97_data, d0);
        tick();
        check("underrun_one_cycle", underrun, 0);
        check("underrun_raddr2", raddr, r0);
        $display("underrun: raddr %0d data %0h held", raddr, to_ac97_data);
        ready_auto = 1;
        finish_seq(1);

        // flush mid-track
        key = 8'h19;
        enq(1); enq(2);
        start = 1'b1; tick(); start = 1'b0;
        reached = 0;
        for (int c = 0; c < 500 && !reached; c++) begin
            tick();
            if (raddr == 23'(TL + 3)) reached = 1;
        end
        check("flush_reach", reached, 1);
        flush = 1'b1; enq_valid = 1'b1; enq_index = 5'd9;
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        mq.delete();
        exp_data = 8'h00;
        check("flush_playing", playing, 0);
        check("flush_q_count", q_count, 0);
        check("flush_raddr", raddr, 0);
        check("flush_doread", doread, 0);
        check("flush_data", to_ac97_data, 0);
        seen = 0;
        repeat (10) begin
            tick();
            if (done) seen++;
        end
        check("flush_no_done", seen, 0);
        $display("flush: idle, queue %0d, raddr %0d", q_count, raddr);

        // recovery after flush
        key = 8'hA5;
        enq(6); enq(28); enq(0);
        run_seq(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
